// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one asynchronous SRAM between a buffered write path
// (4-entry FIFO fed by the SPI command path) and a single-outstanding display
// read path. Reads normally win, but after four consecutive reads with writes
// waiting a write is forced through. Every access is a fixed 2-cycle sequence
// (strobe + capture/release), so the SRAM timing is set by the clock.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   wr_valid/wr_ready     write handshake; wr_addr {page,offset}, wr_data pixel
//   rd_req, rd_addr       one-cycle read request pulse and its address
//   rd_data, rd_valid     captured read word and its one-cycle valid pulse
//   rd_overrun            sticky: a read request arrived while one was pending
//   sram_*                SRAM pins; all are registered, dq_oe never overlaps oe_n=0
module sram_port_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [17:0] wr_addr,
  input  logic [23:0] wr_data,
  input  logic        rd_req,
  input  logic [17:0] rd_addr,
  output logic [23:0] rd_data,
  output logic        rd_valid,
  output logic        rd_overrun,
  output logic [17:0] sram_addr,
  output logic [23:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [23:0] sram_dq_in,
  output logic        sram_we_n,
  output logic        sram_oe_n
);

  localparam int unsigned ADDR_W     = 18;
  localparam int unsigned DATA_W     = 24;
  localparam int unsigned DEPTH      = 4;
  localparam int unsigned PTR_W      = 2;
  localparam int unsigned CNT_W      = 3;
  localparam int unsigned STREAK_W   = 3;
  localparam int unsigned STREAK_MAX = 4;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD_STB = 3'd1;
  localparam logic [2:0] S_RD_CAP = 3'd2;
  localparam logic [2:0] S_WR_STB = 3'd3;
  localparam logic [2:0] S_WR_REL = 3'd4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

  logic [2:0]          r_state, w_state_nxt;
  wr_entry_t           r_fifo [DEPTH];
  wr_entry_t           w_head;
  logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]    r_count, w_count_nxt;
  logic                r_wr_ready;
  logic                w_push, w_pop;
  logic [STREAK_W-1:0] r_rd_streak, w_rd_streak_nxt;
  logic                r_rd_pend;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic [DATA_W-1:0]   r_rd_data;
  logic                r_rd_valid, r_rd_overrun;
  logic                w_rd_clr, w_rd_accept, w_rd_drop;
  logic [ADDR_W-1:0]   r_sram_addr, w_sram_addr_nxt;
  logic [DATA_W-1:0]   r_sram_dq_out, w_sram_dq_out_nxt;
  logic                r_sram_dq_oe, w_sram_dq_oe_nxt;
  logic                r_sram_we_n, w_sram_we_n_nxt;
  logic                r_sram_oe_n, w_sram_oe_n_nxt;

  assign w_head = r_fifo[r_rd_ptr];
  assign w_push = wr_valid & r_wr_ready;
  assign w_pop  = (r_state == S_WR_REL);

  // Pending read retires at the edge ending RD_CAP; a request on that same
  // edge starts a fresh read instead of counting as an overrun.
  assign w_rd_clr    = (r_state == S_RD_CAP);
  assign w_rd_accept = rd_req & (~r_rd_pend | w_rd_clr);
  assign w_rd_drop   = rd_req & r_rd_pend & ~w_rd_clr;

  // Next-state: bounded read priority, writes drain when reads back off.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_rd_pend && (r_rd_streak < STREAK_W'(STREAK_MAX))) begin
          w_state_nxt = S_RD_STB;
        end else if (r_count != '0) begin
          w_state_nxt = S_WR_STB;
        end else if (r_rd_pend) begin
          w_state_nxt = S_RD_STB;
        end
      end
      S_RD_STB: w_state_nxt = S_RD_CAP;
      S_RD_CAP: w_state_nxt = S_IDLE;
      S_WR_STB: w_state_nxt = S_WR_REL;
      S_WR_REL: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // FIFO occupancy; push is already gated by wr_ready so it never overflows.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Consecutive reads granted while writes wait.
  always_comb begin
    w_rd_streak_nxt = r_rd_streak;
    if (r_count == '0) begin
      w_rd_streak_nxt = '0;
    end else if ((r_state == S_IDLE) && (w_state_nxt == S_WR_STB)) begin
      w_rd_streak_nxt = '0;
    end else if ((r_state == S_IDLE) && (w_state_nxt == S_RD_STB) &&
                 (r_rd_streak < STREAK_W'(STREAK_MAX))) begin
      w_rd_streak_nxt = r_rd_streak + STREAK_W'(1);
    end
  end

  // SRAM pins are decoded from the next state and registered, so they line up
  // with the state they belong to. dq_oe is only ever raised in write states.
  always_comb begin
    w_sram_addr_nxt   = r_sram_addr;
    w_sram_dq_out_nxt = r_sram_dq_out;
    w_sram_dq_oe_nxt  = 1'b0;
    w_sram_we_n_nxt   = 1'b1;
    w_sram_oe_n_nxt   = 1'b1;
    case (w_state_nxt)
      S_RD_STB, S_RD_CAP: begin
        w_sram_addr_nxt = r_rd_addr;
        w_sram_oe_n_nxt = 1'b0;
      end
      S_WR_STB: begin
        w_sram_addr_nxt   = w_head.addr;
        w_sram_dq_out_nxt = w_head.data;
        w_sram_dq_oe_nxt  = 1'b1;
        w_sram_we_n_nxt   = 1'b0;
      end
      S_WR_REL: begin
        w_sram_dq_oe_nxt = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // State, FIFO control, read tracking and pin registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_wr_ready    <= 1'b1;
      r_rd_streak   <= '0;
      r_rd_pend     <= 1'b0;
      r_rd_addr     <= '0;
      r_rd_data     <= '0;
      r_rd_valid    <= 1'b0;
      r_rd_overrun  <= 1'b0;
      r_sram_addr   <= '0;
      r_sram_dq_out <= '0;
      r_sram_dq_oe  <= 1'b0;
      r_sram_we_n   <= 1'b1;
      r_sram_oe_n   <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_count     <= w_count_nxt;
      r_wr_ready  <= (w_count_nxt < CNT_W'(DEPTH));
      r_rd_streak <= w_rd_streak_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);

      if (w_rd_accept) begin
        r_rd_pend <= 1'b1;
        r_rd_addr <= rd_addr;
      end else if (w_rd_clr) begin
        r_rd_pend <= 1'b0;
      end
      if (w_rd_drop) r_rd_overrun <= 1'b1;
      if (w_rd_clr)  r_rd_data    <= sram_dq_in;
      r_rd_valid <= w_rd_clr;

      r_sram_addr   <= w_sram_addr_nxt;
      r_sram_dq_out <= w_sram_dq_out_nxt;
      r_sram_dq_oe  <= w_sram_dq_oe_nxt;
      r_sram_we_n   <= w_sram_we_n_nxt;
      r_sram_oe_n   <= w_sram_oe_n_nxt;
    end
  end

  // FIFO storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= {wr_addr, wr_data};
  end

  assign wr_ready    = r_wr_ready;
  assign rd_data     = r_rd_data;
  assign rd_valid    = r_rd_valid;
  assign rd_overrun  = r_rd_overrun;
  assign sram_addr   = r_sram_addr;
  assign sram_dq_out = r_sram_dq_out;
  assign sram_dq_oe  = r_sram_dq_oe;
  assign sram_we_n   = r_sram_we_n;
  assign sram_oe_n   = r_sram_oe_n;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: the stimulus process pushes expected
// reads/writes into queues, a monitor pops them when the DUT shows rd_valid or
// a write strobe on the SRAM pins. A behavioural SRAM array backs the bus.
module tb_sram_port_arbiter;

  localparam logic [17:0] RD_A1   = 18'h20005;
  localparam logic [23:0] RD_D1   = 24'h123456;
  localparam logic [17:0] RD_A2   = 18'h00777;
  localparam logic [23:0] RD_D2   = 24'h0A0B0C;
  localparam logic [17:0] RD_AC   = 18'h00200;
  localparam logic [23:0] RD_DC   = 24'h5A5A5A;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid, wr_ready;
  logic [17:0] wr_addr;
  logic [23:0] wr_data;
  logic        rd_req;
  logic [17:0] rd_addr;
  logic [23:0] rd_data;
  logic        rd_valid, rd_overrun;
  logic [17:0] sram_addr;
  logic [23:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n, sram_oe_n;

  typedef struct {
    logic [23:0] data;
    int          lat;
    int          tag;
  } rd_exp_t;

  typedef struct {
    logic [17:0] addr;
    logic [23:0] data;
    int          cyc;
    int          rb;
  } wr_exp_t;

  rd_exp_t     rq[$];
  wr_exp_t     wq[$];
  logic [23:0] mem [0:262143];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign sram_dq_in = sram_oe_n ? 24'h0 : mem[sram_addr];

  sram_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_overrun(rd_overrun),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h @cyc %0d", name, act, exp, cyc);
    end
  endfunction

  function automatic void chk_true(input string name, input bit cond);
    checks++;
    if (!cond) begin
      errors++;
      $display("FAIL %s actual=false required=true @cyc %0d", name, cyc);
    end
  endfunction

  // Monitor: owns the SRAM array, pops expectations on DUT events.
  initial begin : monitor
    bit          prev_wr;
    logic [17:0] prev_addr;
    int          reads_since;
    wr_exp_t     we;
    rd_exp_t     re;
    prev_wr     = 1'b0;
    prev_addr   = '0;
    reads_since = 0;
    mem[RD_A1]  = RD_D1;
    mem[RD_A2]  = RD_D2;
    mem[RD_AC]  = RD_DC;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        prev_wr     = 1'b0;
        reads_since = 0;
      end else begin
        if (!sram_oe_n) chk("no_bus_contention", sram_dq_oe, 0);
        if (prev_wr) begin
          chk("wr_rel_we_n", sram_we_n, 1);
          chk("wr_rel_dq_oe", sram_dq_oe, 1);
          chk("wr_rel_addr", sram_addr, prev_addr);
          prev_wr = 1'b0;
        end
        if (!sram_we_n) begin
          mem[sram_addr] = sram_dq_out;
          chk_true("write_expected", wq.size() > 0);
          if (wq.size() > 0) begin
            we = wq.pop_front();
            chk("wr_addr", sram_addr, we.addr);
            chk("wr_data", sram_dq_out, we.data);
            chk("wr_dq_oe", sram_dq_oe, 1);
            chk("wr_oe_n", sram_oe_n, 1);
            if (we.cyc >= 0) chk("wr_cycle", cyc, we.cyc);
            if (we.rb >= 0)  chk("reads_before_write", reads_since, we.rb);
          end
          reads_since = 0;
          prev_wr     = 1'b1;
          prev_addr   = sram_addr;
        end
        if (rd_valid) begin
          if (wq.size() > 0) reads_since++;
          chk_true("read_expected", rq.size() > 0);
          if (rq.size() > 0) begin
            re = rq.pop_front();
            chk("rd_data", rd_data, re.data);
            if (re.lat >= 0) chk("rd_latency", cyc - re.tag, re.lat);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic wait_drain();
    for (int i = 0; i < 200 && (rq.size() > 0 || wq.size() > 0); i++) @(negedge clk);
    chk("drain_reads", rq.size(), 0);
    chk("drain_writes", wq.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_read(input logic [17:0] a, input logic [23:0] d, input int lat);
    @(negedge clk);
    rd_req  = 1'b1;
    rd_addr = a;
    rq.push_back('{d, lat, cyc});
    @(negedge clk);
    rd_req = 1'b0;
    wait_drain();
  endtask

  // Reads re-issued in each RD_CAP cycle keep the read side continuously busy.
  task automatic run_mixed(input int rd_cycles, input int wr_start, input int nwr,
                           input logic [17:0] wa0, input logic [23:0] wd0,
                           input int rb, input bit chk_full);
    int acc;
    bit prev_oel, full_pend, done;
    acc = 0; prev_oel = 1'b0; full_pend = 1'b0; done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (full_pend) begin
        chk("fifo_full_wr_ready", wr_ready, 0);
        full_pend = 1'b0;
      end
      rd_req   = (c < rd_cycles) && ((c == 0) || (!sram_oe_n && prev_oel));
      prev_oel = !sram_oe_n;
      rd_addr  = RD_AC;
      if (rd_req) rq.push_back('{RD_DC, -1, cyc});
      wr_valid = (c >= wr_start) && (acc < nwr);
      wr_addr  = wa0 + 18'(acc);
      wr_data  = wd0 + 24'(acc);
      if (wr_valid && wr_ready) begin
        wq.push_back('{wr_addr, wr_data, -1, rb});
        acc++;
        if (chk_full && acc == 4) full_pend = 1'b1;
      end
      done = (c >= rd_cycles) && (acc == nwr);
    end
    chk_true("mixed_completes", done);
    @(negedge clk);
    wr_valid = 1'b0;
    rd_req   = 1'b0;
    wait_drain();
  endtask

  initial begin : stim
    int t;
    rst_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    rd_req = 1'b0; rd_addr = '0;
    repeat (2) @(negedge clk);
    chk("rst_we_n", sram_we_n, 1);
    chk("rst_oe_n", sram_oe_n, 1);
    chk("rst_dq_oe", sram_dq_oe, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_dq_out", sram_dq_out, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_overrun", rd_overrun, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_wr_ready", wr_ready, 1);

    // Single write, then a second write pushed on the pop cycle.
    @(negedge clk);
    t = cyc;
    wr_valid = 1'b1; wr_addr = 18'h00010; wr_data = 24'hABCDEF;
    wq.push_back('{18'h00010, 24'hABCDEF, t + 2, -1});
    @(negedge clk);
    wr_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("wr_ready_pop_cycle", wr_ready, 1);
    wr_valid = 1'b1; wr_addr = 18'h00020; wr_data = 24'h654321;
    wq.push_back('{18'h00020, 24'h654321, t + 5, -1});
    @(negedge clk);
    wr_valid = 1'b0;
    wait_drain();

    // Single reads straight from IDLE, including readback of the writes.
    do_read(RD_A1, RD_D1, 4);
    do_read(18'h00010, 24'hABCDEF, 4);
    do_read(18'h00020, 24'h654321, 4);

    // Read arriving while a write is in flight.
    @(negedge clk);
    wr_valid = 1'b1; wr_addr = 18'h00030; wr_data = 24'h111111;
    wq.push_back('{18'h00030, 24'h111111, cyc + 2, -1});
    @(negedge clk);
    wr_valid = 1'b0;
    rd_req = 1'b1; rd_addr = RD_A2;
    rq.push_back('{RD_D2, 6, cyc});
    @(negedge clk);
    rd_req = 1'b0;
    wait_drain();

    // Overrun: second request one cycle later is dropped.
    chk("overrun_clear_before", rd_overrun, 0);
    @(negedge clk);
    rd_req = 1'b1; rd_addr = RD_A1;
    rq.push_back('{RD_D1, 4, cyc});
    @(negedge clk);
    rd_req = 1'b1; rd_addr = 18'h0BEEF;
    @(negedge clk);
    rd_req = 1'b0;
    chk("overrun_set", rd_overrun, 1);
    wait_drain();
    chk("overrun_sticky", rd_overrun, 1);

    // Starvation guard: 2 writes queued behind continuous reads.
    run_mixed(40, 0, 2, 18'h00100, 24'h300000, 4, 1'b0);

    // FIFO full while reads keep the bus busy; fifth write held by the source.
    run_mixed(24, 2, 5, 18'h00110, 24'h400000, -1, 1'b1);

    // Reset in the middle of a write strobe.
    @(negedge clk);
    wr_valid = 1'b1; wr_addr = 18'h00300; wr_data = 24'h777777;
    wq.push_back('{18'h00300, 24'h777777, cyc + 2, -1});
    @(negedge clk);
    wr_addr = 18'h00301; wr_data = 24'h888888;
    wq.push_back('{18'h00301, 24'h888888, -1, -1});
    @(negedge clk);
    wr_valid = 1'b0;
    chk("pre_reset_we_n", sram_we_n, 0);
    rst_n = 1'b0;
    #1;
    chk("reset_we_n", sram_we_n, 1);
    chk("reset_dq_oe", sram_dq_oe, 0);
    chk("reset_oe_n", sram_oe_n, 1);
    chk("reset_overrun", rd_overrun, 0);
    wq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_wr_ready", wr_ready, 1);
    repeat (10) @(negedge clk);
    chk("final_reads", rq.size(), 0);
    chk("final_writes", wq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
